// File: rtl/signed_to_db_meter.sv
// Signed sample to dB-below-full-scale converter with start/ready handshake,
// channel tagging and per-channel peak-hold registers with tick-driven decay.
module signed_to_db_meter #(
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned MANT_BITS = 4,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned FLOOR_DB  = 72,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CH_W-1:0]               channel_in,
  input  logic [IN_WIDTH-1:0]           input_sample,
  input  logic                          decay_tick,
  output logic                          ready,
  output logic                          done,
  output logic [OUT_WIDTH-1:0]          output_db,
  output logic [CH_W-1:0]               channel_out,
  output logic [CHANNELS*OUT_WIDTH-1:0] peak_db
);

  localparam int unsigned K_W       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned G_W       = 16;
  localparam int unsigned R_N       = 2 ** MANT_BITS;
  localparam int unsigned PAD_W     = IN_WIDTH - 1 + MANT_BITS;
  localparam int unsigned OUT_MAX   = (2 ** OUT_WIDTH) - 1;
  localparam int unsigned PEAK_CEIL = (FLOOR_DB < OUT_MAX) ? FLOOR_DB : OUT_MAX;
  localparam logic [OUT_WIDTH-1:0] PEAK_CEIL_V = OUT_WIDTH'(PEAK_CEIL);

  // G_M(k) = round(80*k*log10 2), integer fixed point with 1e-9 resolution
  function automatic logic [IN_WIDTH*G_W-1:0] build_gm();
    logic [IN_WIDTH*G_W-1:0] t;
    t = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      t[k*G_W +: G_W] = G_W'((64'(k) * 64'd24082399653 + 64'd500000000) / 64'd1000000000);
    end
    return t;
  endfunction

  // G_R(r) = round(80*log10(1 + r/2^MANT_BITS)) via bitwise Q30 log2 by repeated squaring
  function automatic logic [R_N*G_W-1:0] build_gr();
    logic [R_N*G_W-1:0] t;
    longint unsigned    y;
    longint unsigned    acc;
    t = '0;
    for (int r = 0; r < R_N; r++) begin
      y   = (64'(R_N + r) << 30) / 64'(R_N);
      acc = 64'd0;
      for (int i = 29; i >= 0; i--) begin
        y = (y * y) >> 30;
        if (y >= (64'd2 << 30)) begin
          y   = y >> 1;
          acc = acc | (64'd1 << i);
        end
      end
      t[r*G_W +: G_W] = G_W'((acc * 64'd24082400 + (64'd1000000 << 29)) / (64'd1000000 << 30));
    end
    return t;
  endfunction

  localparam logic [IN_WIDTH*G_W-1:0] GM_TAB = build_gm();
  localparam logic [R_N*G_W-1:0]      GR_TAB = build_gr();

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_OUT} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [IN_WIDTH-1:0]          mag;
  logic [K_W-1:0]               k;
  logic [CH_W-1:0]              ch_q;
  logic                         accept_c;
  logic [IN_WIDTH-1:0]          abs_c;
  logic [PAD_W-1:0]             pad_c;
  logic [MANT_BITS-1:0]         r_c;
  logic [G_W-1:0]               gm_c;
  logic [G_W-1:0]               gr_c;
  logic [31:0]                  db_full_c;
  logic [OUT_WIDTH-1:0]         db_c;
  logic [OUT_WIDTH-1:0]         pk_cur_c;
  logic [OUT_WIDTH-1:0]         pk_dec_c;
  logic [CHANNELS*OUT_WIDTH-1:0] peak_nxt_c;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: normalise until the leading one reaches the MSB or mag is zero
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept_c) state_nxt = S_NORM;
      S_NORM:  if (mag == '0 || mag[IN_WIDTH-1]) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake decode, magnitude and table lookup
  always_comb begin
    ready     = (state == S_IDLE);
    accept_c  = ready && start;
    abs_c     = input_sample[IN_WIDTH-1] ? (~input_sample + 1'b1) : input_sample;
    pad_c     = {mag[IN_WIDTH-2:0], {MANT_BITS{1'b0}}};
    r_c       = MANT_BITS'(pad_c >> (PAD_W - MANT_BITS));
    gm_c      = GM_TAB[k*G_W +: G_W];
    gr_c      = GR_TAB[r_c*G_W +: G_W];
    db_full_c = 32'd0;
    if (mag == '0)        db_full_c = 32'(FLOOR_DB);
    else if (gm_c > gr_c) db_full_c = 32'(gm_c - gr_c) >> 2;
    db_c = (db_full_c > OUT_MAX) ? OUT_WIDTH'(OUT_MAX) : OUT_WIDTH'(db_full_c);
  end

  // Conversion datapath and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag         <= '0;
      k           <= '0;
      ch_q        <= '0;
      done        <= 1'b0;
      output_db   <= '0;
      channel_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept_c) begin
            mag  <= abs_c;
            k    <= '0;
            ch_q <= channel_in;
          end
        end
        S_NORM: begin
          if (mag != '0 && !mag[IN_WIDTH-1]) begin
            mag <= {mag[IN_WIDTH-2:0], 1'b0};
            k   <= k + 1'b1;
          end
        end
        S_OUT: begin
          done        <= 1'b1;
          output_db   <= db_c;
          channel_out <= ch_q;
        end
        default: ;
      endcase
    end
  end

  // Peak hold: decay is applied before the min with a coincident result
  always_comb begin
    peak_nxt_c = peak_db;
    pk_cur_c   = '0;
    pk_dec_c   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pk_cur_c = peak_db[c*OUT_WIDTH +: OUT_WIDTH];
      pk_dec_c = (decay_tick && pk_cur_c < PEAK_CEIL_V) ? pk_cur_c + 1'b1 : pk_cur_c;
      if (done && channel_out == CH_W'(c) && output_db < pk_dec_c) pk_dec_c = output_db;
      peak_nxt_c[c*OUT_WIDTH +: OUT_WIDTH] = pk_dec_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) peak_db <= {CHANNELS{PEAK_CEIL_V}};
    else       peak_db <= peak_nxt_c;
  end

endmodule

// File: doc/signed_to_db_meter.md
Name: signed_to_db_meter

Overview:
- Parametrised, multi-channel successor to the team's 12-bit signed-to-dB converter.
- Converts a signed sample of any width to attenuation below full scale, in whole dB, using a normalise-then-lookup algorithm.
- Adds a start/ready handshake, channel tagging, and per-channel peak-hold registers with tick-driven decay.
- Sits between the audio sample path and the level-display/trigger logic.

Parameters:
- IN_WIDTH, 12, signed input sample width (min 4).
- MANT_BITS, 4, mantissa bits taken below the leading one.
- CHANNELS, 2, number of peak-hold channels; CH_W = max(1, clog2(CHANNELS)).
- OUT_WIDTH, 8, unsigned dB output width.
- FLOOR_DB, 72, attenuation reported for zero input; also the peak reset/decay ceiling.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request conversion; accepted when start && ready.
- channel_in  in  CH_W  channel tag, captured on accept.
- input_sample  in  IN_WIDTH  signed two's-complement sample, captured on accept.
- decay_tick  in  1  one-cycle pulse; every peak decays by 1 dB.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; output_db and channel_out are valid.
- output_db  out  OUT_WIDTH  attenuation in dB (0 = full scale).
- channel_out  out  CH_W  tag of the result.
- peak_db  out  CHANNELS*OUT_WIDTH  per-channel minimum attenuation; channel c occupies bits [c*OUT_WIDTH +: OUT_WIDTH].

Behaviour:
- Reset (asynchronous):
  - state=IDLE; done=0; output_db=0; channel_out=0.
  - every peak = min(FLOOR_DB, 2^OUT_WIDTH-1).
  - Reset mid-conversion aborts the conversion with no done pulse.
- Lookup tables, built at elaboration:
  - G_M(k) = round(80*k*log10 2), for k = 0..IN_WIDTH-1.
  - G_R(r) = round(80*log10(1 + r/2^MANT_BITS)). For MANT_BITS=4 this gives 0,2,4,6,8,9,11,13,14,16,17,18,19,21,22,23.
- IDLE:
  - On accept, register mag = |input_sample| as an IN_WIDTH-bit unsigned value. The most negative input maps to 2^(IN_WIDTH-1).
  - Clear k, capture the channel tag, go to NORMALISE.
- NORMALISE, one decision per cycle:
  - If mag==0, go to OUTPUT with the zero flag set.
  - Else if mag[IN_WIDTH-1]==1, set r = mag[IN_WIDTH-2 -: MANT_BITS] and go to OUTPUT. Bits shifted in are zeros, so short mantissas are zero-padded at the LSB.
  - Else shift mag left by 1 and increment k.
- OUTPUT:
  - output_db = zero flag ? FLOOR_DB : max(0, G_M(k) - G_R(r)) >> 2 (floor division).
  - Saturate the result to 2^OUT_WIDTH-1.
  - Pulse done, go to IDLE.
- Latency from the accept edge to done high:
  - k+2 cycles for a nonzero sample, where k = IN_WIDTH-1-(index of the leading one).
  - 2 cycles for zero.
- Throughput: ready is high during the done cycle, so a back-to-back accept is legal.
- Peak update, per channel c each cycle:
  - dec = decay_tick ? min(peak+1, FLOOR_DB) : peak.
  - If done && channel_out==c, peak = min(dec, output_db); otherwise peak = dec.
  - A tick coinciding with an update is applied before the min.
- channel_in >= CHANNELS: conversion and done behave normally, but no peak is updated.
- start while busy is ignored; no queuing.
- Inputs are sampled only on the accept edge, so later input changes have no effect.

Test Plan:
- Accept 12'sd2047 on ch0 -> done 3 cycles after accept; output_db=0; channel_out=0; peak0=0.
- Accept -12'sd2048 -> done after 2 cycles; output_db=0. Accept 12'sd1 -> done after 13 cycles; output_db=66 (265>>2).
- Accept 0 -> done after 2 cycles; output_db=72.
- Accept -384 on ch1 -> k=3, r=8, (72-14)>>2 gives output_db=14, peak1=14. Then 256 -> 18, peak1 stays 14. Then 3 decay_ticks -> peak1=17.
- Back-to-back: start held high with 2047 then 1 -> second accept occurs in the first done cycle; second done 13 cycles later; values are not corrupted.
- Assert reset during NORMALISE (sample 1) -> ready=1 and done=0 immediately; all peaks=72; no done pulse follows.
